zeroriscy_irq_arbiter: RTL and testbench

Collects external interrupt lines and latches each rising edge as a pending request. Selects the highest-priority pending line and offers it to the core controller with a hold-until-ack handshake. On acceptance it drives the CSR unit's cause/save inputs (csr_cause, csr_save_cause) and returns an acknowledge to the interrupt source. It sits directly upstream of zeroriscy_cs_registers and gates requests with that block's m_irq_enable output.

---
 rtl/zeroriscy_irq_arbiter.sv | 165 ++++++++++++++++
 tb/tb_zeroriscy_irq_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_irq_arbiter.sv
// Interrupt arbiter: rising-edge capture of irq lines, lowest-index-first offer to the controller.
// Latency: edge -> pending +1 cycle, -> request +2 cycles (+2 more with ZERORISCY_IRQ_SYNC_EN).
// Backpressure: the offered ID is held until the controller acks it or MIE drops (then withdrawn, kept pending).
//
// Optional build macro: ZERORISCY_IRQ_SYNC_EN inserts a 2-flop synchroniser on irq_i.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   irq_i                    level interrupt lines; a 0->1 transition is a request
//   m_irq_enable_i           mstatus.MIE from the CSR unit
//   irq_req_ctrl_o/_id_      request + ID to the controller, stable until ack/withdraw
//   irq_ack_ctrl_i           controller accepts the offered interrupt
//   csr_save_cause_o/cause_o one-cycle cause write to the CSR unit ({1'b1, id})
//   irq_ack_o/irq_ack_id_o   one-cycle acknowledge back to the source
//   irq_pending_o            current pending vector
module zeroriscy_irq_arbiter #(
    parameter int N_IRQ = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             m_irq_enable_i,
    output logic             irq_req_ctrl_o,
    output logic [4:0]       irq_id_ctrl_o,
    input  logic             irq_ack_ctrl_i,
    output logic             csr_save_cause_o,
    output logic [5:0]       csr_cause_o,
    output logic             irq_ack_o,
    output logic [4:0]       irq_ack_id_o,
    output logic [N_IRQ-1:0] irq_pending_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [N_IRQ-1:0] w_irq_in;
    logic [N_IRQ-1:0] r_irq_q;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] w_set_vec;
    logic [N_IRQ-1:0] w_clr_vec;
    logic [N_IRQ-1:0] w_pending_nxt;
    logic [4:0]       r_id;
    logic [4:0]       w_sel_id;
    logic             w_sel_valid;
    logic             w_id_load;
    logic             w_in_req;
    logic             w_in_ack;

`ifdef ZERORISCY_IRQ_SYNC_EN
    logic [N_IRQ-1:0] r_sync1;
    logic [N_IRQ-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_in = r_sync2;
`else
    assign w_irq_in = irq_i;
`endif

    // Edge detect: irq_q resets low, so a line already high when reset
    // releases counts as a fresh request.
    assign w_set_vec = w_irq_in & ~r_irq_q;

    // Clear only the ID being acknowledged this cycle.
    always_comb begin
        w_clr_vec = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (w_in_ack && (r_id == 5'(k))) begin
                w_clr_vec[k] = 1'b1;
            end
        end
    end

    // OR-ing the set vector last makes a new edge win over a same-cycle clear.
    assign w_pending_nxt = (r_pending & ~w_clr_vec) | w_set_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_q   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_q   <= w_irq_in;
            r_pending <= w_pending_nxt;
        end
    end

    // Lowest index wins: scan downwards so the last hit is the lowest set bit.
    always_comb begin
        w_sel_id = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_sel_id = 5'(k);
            end
        end
    end

    assign w_sel_valid = |r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_id_load) begin
                r_id <= w_sel_id;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_valid && m_irq_enable_i) begin
                    w_id_load   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // Ack takes precedence over a simultaneous MIE drop.
                if (irq_ack_ctrl_i) begin
                    w_state_nxt = S_ACK;
                end else if (!m_irq_enable_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state/id flops, so they are glitch-free
    // and zero whenever not valid.
    assign w_in_req = (r_state == S_REQ);
    assign w_in_ack = (r_state == S_ACK);

    assign irq_req_ctrl_o   = w_in_req;
    assign irq_id_ctrl_o    = w_in_req ? r_id : 5'd0;
    assign csr_save_cause_o = w_in_ack;
    assign csr_cause_o      = w_in_ack ? {1'b1, r_id} : 6'd0;
    assign irq_ack_o        = w_in_ack;
    assign irq_ack_id_o     = w_in_ack ? r_id : 5'd0;
    assign irq_pending_o    = r_pending;

endmodule

// File: tb/tb_zeroriscy_irq_arbiter.sv
module tb_zeroriscy_irq_arbiter;

`ifdef ZERORISCY_IRQ_SYNC_EN
    localparam int X = 2;
`else
    localparam int X = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq;
    logic        en;
    logic        ack_in;
    logic        req;
    logic [4:0]  req_id;
    logic        save;
    logic [5:0]  cause;
    logic        ack_out;
    logic [4:0]  ack_id;
    logic [31:0] pend;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    zeroriscy_irq_arbiter #(.N_IRQ(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .irq_i            (irq),
        .m_irq_enable_i   (en),
        .irq_req_ctrl_o   (req),
        .irq_id_ctrl_o    (req_id),
        .irq_ack_ctrl_i   (ack_in),
        .csr_save_cause_o (save),
        .csr_cause_o      (cause),
        .irq_ack_o        (ack_out),
        .irq_ack_id_o     (ack_id),
        .irq_pending_o    (pend)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; irq = '0; en = 1'b0; ack_in = 1'b0;
        #2;
        check("rst_req",    32'(req),     32'h0);
        check("rst_id",     32'(req_id),  32'h0);
        check("rst_save",   32'(save),    32'h0);
        check("rst_cause",  32'(cause),   32'h0);
        check("rst_ack",    32'(ack_out), 32'h0);
        check("rst_ackid",  32'(ack_id),  32'h0);
        check("rst_pend",   pend,         32'h0);
        step(3);
        rst = 1'b0;
        step(2);
        check("idle_req", 32'(req), 32'h0);

        // Single line 5, held high.
        en = 1'b1; irq = 32'h20;
        step(1 + X);
        check("t1_pend",    pend,        32'h20);
        check("t1_noreq",   32'(req),    32'h0);
        step(1);
        check("t1_req",     32'(req),    32'h1);
        check("t1_id",      32'(req_id), 32'h5);
        step(1);
        check("t1_hold",    32'(req),    32'h1);
        step(1);
        ack_in = 1'b1;
        check("t1_hold2",   32'(req_id), 32'h5);
        step(1);
        ack_in = 1'b0;
        check("t1_save",    32'(save),    32'h1);
        check("t1_cause",   32'(cause),   32'h25);
        check("t1_ack",     32'(ack_out), 32'h1);
        check("t1_ackid",   32'(ack_id),  32'h5);
        check("t1_reqoff",  32'(req),     32'h0);
        step(1);
        check("t1_pend0",   pend,         32'h0);
        check("t1_save0",   32'(save),    32'h0);
        check("t1_ack0",    32'(ack_out), 32'h0);
        step(6);
        check("t1_noreq2",  32'(req),     32'h0);
        check("t1_pend0b",  pend,         32'h0);
        irq = '0;
        step(2 + X);

        // Lines 3 and 9 together: 3 first.
        irq = 32'h208;
        step(1 + X);
        check("t2_pend",    pend,        32'h208);
        step(1);
        check("t2_id3",     32'(req_id), 32'h3);
        ack_in = 1'b1;
        step(1);
        ack_in = 1'b0; en = 1'b0;
        check("t2_cause3",  32'(cause),  32'h23);
        check("t2_ackid3",  32'(ack_id), 32'h3);
        step(1);
        check("t2_pend9",   pend,        32'h200);
        step(3);
        check("t2_dis",     32'(req),    32'h0);
        en = 1'b1;
        step(1);
        check("t2_req9",    32'(req),    32'h1);
        check("t2_id9",     32'(req_id), 32'h9);
        ack_in = 1'b1;
        step(1);
        ack_in = 1'b0;
        check("t2_cause9",  32'(cause),  32'h29);
        check("t2_ackid9",  32'(ack_id), 32'h9);
        step(1);
        check("t2_pend0",   pend,        32'h0);
        irq = '0;
        step(2 + X);

        // Enable gating and withdraw, then ack beats a same-cycle enable drop.
        en = 1'b0; irq = 32'h80;
        step(4 + X);
        check("t3_pend",    pend,        32'h80);
        check("t3_noreq",   32'(req),    32'h0);
        en = 1'b1;
        step(1);
        check("t3_req",     32'(req),    32'h1);
        check("t3_id",      32'(req_id), 32'h7);
        en = 1'b0;
        step(1);
        check("t4_wdraw",   32'(req),    32'h0);
        check("t4_kept",    pend,        32'h80);
        en = 1'b1;
        step(1);
        check("t4_reoffer", 32'(req_id), 32'h7);
        ack_in = 1'b1; en = 1'b0;
        step(1);
        ack_in = 1'b0;
        check("t4_save",    32'(save),   32'h1);
        check("t4_cause",   32'(cause),  32'h27);
        step(1);
        check("t4_pend0",   pend,        32'h0);
        check("t4_req0",    32'(req),    32'h0);
        en = 1'b1; irq = '0;
        step(2 + X);

        // Line 2: second rising edge lands on the ACK cycle of the first.
        irq = 32'h4;
        for (int t = 1; t <= 10 + X; t++) begin
            step(1);
            if (t == 1)     irq = '0;
            if (t == 3)     irq = 32'h4;
            if (t == 1 + X) check("t5_pend",   pend,        32'h4);
            if (t == 2 + X) begin
                check("t5_req", 32'(req_id), 32'h2);
                ack_in = 1'b1;
            end
            if (t == 3 + X) begin
                ack_in = 1'b0;
                check("t5_cause", 32'(cause), 32'h22);
            end
            if (t == 4 + X) check("t5_setwins", pend,        32'h4);
            if (t == 5 + X) begin
                check("t5_reoff", 32'(req), 32'h1);
                check("t5_reid",  32'(req_id), 32'h2);
            end
            if (t == 6 + X) ack_in = 1'b1;
            if (t == 7 + X) begin
                ack_in = 1'b0;
                check("t5_cause2", 32'(ack_id), 32'h2);
            end
            if (t == 8 + X) check("t5_pend0",  pend,        32'h0);
        end
        irq = '0;
        step(3 + X);

        // Reset while in REQ.
        irq = 32'h10;
        step(2 + X);
        check("t6_req",     32'(req),    32'h1);
        check("t6_id",      32'(req_id), 32'h4);
        rst = 1'b1;
        #1;
        check("t6_rreq",    32'(req),    32'h0);
        check("t6_rid",     32'(req_id), 32'h0);
        check("t6_rpend",   pend,        32'h0);
        check("t6_rsave",   32'(save),   32'h0);
        step(2);
        rst = 1'b0;
        step(1 + X);
        check("t6_recap",   pend,        32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
